// File: rtl/demosaic_pkg.sv
// Shared definitions for the demosaic stream controller: state encoding, default geometry, clog2 helper.
package demosaic_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_SOF = 3'd1;
  localparam logic [2:0] S_LINE     = 3'd2;
  localparam logic [2:0] S_HBLANK   = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_WAIT_SOF = S_WAIT_SOF,
    ST_LINE     = S_LINE,
    ST_HBLANK   = S_HBLANK,
    ST_FLUSH    = S_FLUSH,
    ST_DONE     = S_DONE
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_NCOL        = 349;
  localparam int DEF_NROWS       = 349;
  localparam int DEF_HBLANK      = 4;
  localparam int DEF_FLUSH_LINES = 1;

  // Never returns less than 1 so counters of degenerate sizes still have a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/demosaic_line_timer.sv
// Column/row/blanking counters for the demosaic stream controller; strobes are decoded from counter values.
module demosaic_line_timer
  import demosaic_pkg::*;
#(
  parameter int NCOL        = DEF_NCOL,
  parameter int NROWS       = DEF_NROWS,
  parameter int HBLANK      = DEF_HBLANK,
  parameter int FLUSH_LINES = DEF_FLUSH_LINES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pix_adv,
  input  logic blank_adv,
  output logic end_of_line,
  output logic end_of_frame,
  output logic end_of_flush,
  output logic flush_rows,
  output logic blank_done
);

  localparam int CW = clog2(NCOL);
  localparam int RW = clog2(NROWS + FLUSH_LINES);
  localparam int BW = clog2(HBLANK + 1);

  localparam logic [CW-1:0] COL_LAST     = CW'(NCOL - 1);
  localparam logic [RW-1:0] ROW_IMG_LAST = RW'(NROWS - 1);
  localparam logic [RW-1:0] ROW_FLUSH0   = RW'(NROWS);
  localparam logic [RW-1:0] ROW_LAST     = RW'(NROWS + FLUSH_LINES - 1);
  localparam logic [BW-1:0] BLANK_LAST   = BW'(HBLANK - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] blank;

  // The SOF pixel occupies col 0 as it is accepted, so the line continues from col 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      blank <= '0;
    end else begin
      if (start) begin
        col <= CW'(1);
        row <= '0;
      end else if (pix_adv) begin
        if (end_of_line) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (blank_adv) blank <= blank_done ? '0 : blank + 1'b1;
    end
  end

  assign end_of_line  = (col == COL_LAST);
  assign end_of_frame = end_of_line && (row == ROW_IMG_LAST);
  assign end_of_flush = end_of_line && (row == ROW_LAST);
  assign flush_rows   = (row >= ROW_FLUSH0);
  assign blank_done   = (blank == BLANK_LAST);

endmodule

// File: rtl/demosaic_stream_ctrl.sv
// Gap-free frame sequencer feeding the 3x3 Bayer demosaic kernel (tuser/tlast generation, blanking, flush lines).
// Optional statistics counters are enabled by defining DEMOSAIC_CTRL_STATS_EN.
module demosaic_stream_ctrl
  import demosaic_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NCOL        = DEF_NCOL,
  parameter int NROWS       = DEF_NROWS,
  parameter int HBLANK      = DEF_HBLANK,
  parameter int FLUSH_LINES = DEF_FLUSH_LINES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              busy,
  output logic              frame_done,
  output logic              err_line_len,
  output logic              err_underrun
`ifdef DEMOSAIC_CTRL_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       underrun_cnt
`endif
);

  state_t state, state_nxt;

  logic start, pix_adv, blank_adv;
  logic end_of_line, end_of_frame, end_of_flush, flush_rows, blank_done;
  logic arm, underrun;

  logic [DATA_W-1:0] data_p0;
  logic              vld_p0, user_p0, last_p0, fdone_p0;

  demosaic_line_timer #(
    .NCOL       (NCOL),
    .NROWS      (NROWS),
    .HBLANK     (HBLANK),
    .FLUSH_LINES(FLUSH_LINES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pix_adv     (pix_adv),
    .blank_adv   (blank_adv),
    .end_of_line (end_of_line),
    .end_of_frame(end_of_frame),
    .end_of_flush(end_of_flush),
    .flush_rows  (flush_rows),
    .blank_done  (blank_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Blanking is shared between image and flush lines; the row counter picks where it returns.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    start         = 1'b0;
    pix_adv       = 1'b0;
    blank_adv     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tuser) begin
          start     = 1'b1;
          state_nxt = ST_LINE;
        end
      end
      ST_LINE: begin
        s_axis_tready = 1'b1;
        pix_adv       = 1'b1;
        if (end_of_line) state_nxt = end_of_frame ? ST_FLUSH : ST_HBLANK;
      end
      ST_HBLANK: begin
        blank_adv = 1'b1;
        if (blank_done) state_nxt = flush_rows ? ST_FLUSH : ST_LINE;
      end
      ST_FLUSH: begin
        pix_adv = 1'b1;
        if (end_of_line) state_nxt = end_of_flush ? ST_DONE : ST_HBLANK;
      end
      ST_DONE: begin
        state_nxt = enable ? ST_WAIT_SOF : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign arm      = (state == ST_IDLE) && enable;
  assign underrun = (state == ST_LINE) && !s_axis_tvalid;

  // Stage p0: registered output beat; data holds through gaps so an underrun repeats the last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0  <= '0;
      vld_p0   <= 1'b0;
      user_p0  <= 1'b0;
      last_p0  <= 1'b0;
      fdone_p0 <= 1'b0;
    end else begin
      fdone_p0 <= (state == ST_DONE);
      user_p0  <= start;
      case (state)
        ST_WAIT_SOF: begin
          vld_p0  <= start;
          last_p0 <= 1'b0;
          if (start) data_p0 <= s_axis_tdata;
        end
        ST_LINE: begin
          vld_p0  <= 1'b1;
          last_p0 <= end_of_line;
          if (s_axis_tvalid) data_p0 <= s_axis_tdata;
        end
        ST_FLUSH: begin
          vld_p0  <= 1'b1;
          last_p0 <= end_of_line;
          data_p0 <= '0;
        end
        default: begin
          vld_p0  <= 1'b0;
          last_p0 <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      err_line_len <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      if (start && s_axis_tlast) err_line_len <= 1'b1;
      if (state == ST_LINE) begin
        if (!s_axis_tvalid) err_underrun <= 1'b1;
        if (s_axis_tvalid && s_axis_tuser) err_line_len <= 1'b1;
        if (end_of_line ? !(s_axis_tvalid && s_axis_tlast) : (s_axis_tvalid && s_axis_tlast))
          err_line_len <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid = vld_p0;
  assign m_axis_tuser  = user_p0;
  assign m_axis_tlast  = last_p0;
  assign m_axis_tdata  = data_p0;
  assign frame_done    = fdone_p0;
  assign busy          = (state != ST_IDLE);

`ifdef DEMOSAIC_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      if (fdone_p0) frame_cnt <= frame_cnt + 16'd1;
      if (underrun) underrun_cnt <= sat_inc16(underrun_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_demosaic_stream_ctrl.sv
// Directed self-checking bench for demosaic_stream_ctrl (NCOL=8, NROWS=4, HBLANK=2, FLUSH_LINES=1).
module tb_demosaic_stream_ctrl;

  localparam int DATA_W      = 8;
  localparam int NCOL        = 8;
  localparam int NROWS       = 4;
  localparam int HBLANK      = 2;
  localparam int FLUSH_LINES = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tuser = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              busy, frame_done, err_line_len, err_underrun;
`ifdef DEMOSAIC_CTRL_STATS_EN
  logic [15:0]       frame_cnt, underrun_cnt;
`endif

  int checks = 0;
  int failures = 0;

  demosaic_stream_ctrl #(
    .DATA_W(DATA_W), .NCOL(NCOL), .NROWS(NROWS), .HBLANK(HBLANK), .FLUSH_LINES(FLUSH_LINES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_line_len (err_line_len),
    .err_underrun (err_underrun)
`ifdef DEMOSAIC_CTRL_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    chk1({tag, "_tuser"}, m_axis_tuser, 1'b0);
    chk1({tag, "_tlast"}, m_axis_tlast, 1'b0);
    chk8({tag, "_tdata"}, m_axis_tdata, 8'h00);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, frame_done, 1'b0);
    chk1({tag, "_errll"}, err_line_len, 1'b0);
    chk1({tag, "_errur"}, err_underrun, 1'b0);
    chk1({tag, "_tready"}, s_axis_tready, 1'b0);
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    if (r == 0 && c == 0) return 8'hA5;
    return 8'(8'h40 + r * 8 + c);
  endfunction

  // One frame from IDLE/WAIT_SOF: optional junk pixels before SOF, an underrun gap on row 1,
  // a misplaced source tlast column, and an optional reset abort at (abort_row, abort_col).
  task automatic do_frame(input int junk, input int gap_col, input int gap_len, input int tl_col,
                          input int abort_row, input int abort_col, input logic keep_en);
    logic [7:0] last_d, exp_d;
    logic ur, ll, v;
    last_d = 8'h00;
    ur = 1'b0;
    ll = 1'b0;
    enable = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    step();
    chk1("armed_busy", busy, 1'b1);
    chk1("armed_errll", err_line_len, 1'b0);
    chk1("armed_errur", err_underrun, 1'b0);
    for (int j = 0; j < junk; j++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = (j == 0) ? 8'h11 : 8'h22;
      step();
      chk1("junk_dropped", m_axis_tvalid, 1'b0);
    end
    for (int r = 0; r < NROWS; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        if (r == abort_row && c == abort_col) begin
          rst = 1'b1; enable = 1'b0; s_axis_tvalid = 1'b0;
          step();
          chk_quiet("abort");
          rst = 1'b0;
          for (int k = 0; k < 2 * NCOL; k++) begin
            step();
            chk1("abort_no_done", frame_done, 1'b0);
            chk1("abort_idle", busy, 1'b0);
          end
          return;
        end
        chk1("line_tready", s_axis_tready, 1'b1);
        v = !(r == 1 && c >= gap_col && c < gap_col + gap_len);
        s_axis_tvalid = v;
        s_axis_tdata  = pix(r, c);
        s_axis_tuser  = (r == 0 && c == 0);
        s_axis_tlast  = (c == tl_col);
        if (!v) ur = 1'b1;
        if ((v && c == tl_col) != (c == NCOL - 1)) ll = 1'b1;
        step();
        exp_d = v ? pix(r, c) : last_d;
        last_d = exp_d;
        chk1("pix_tvalid", m_axis_tvalid, 1'b1);
        chk8("pix_tdata", m_axis_tdata, exp_d);
        chk1("pix_tuser", m_axis_tuser, (r == 0 && c == 0));
        chk1("pix_tlast", m_axis_tlast, (c == NCOL - 1));
      end
      if (r < NROWS - 1) begin
        for (int b = 0; b < HBLANK; b++) begin
          s_axis_tvalid = 1'b1; s_axis_tdata = pix(r + 1, 0);
          s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
          chk1("blank_tready", s_axis_tready, 1'b0);
          step();
          chk1("blank_tvalid", m_axis_tvalid, 1'b0);
        end
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    for (int f = 0; f < FLUSH_LINES; f++) begin
      if (f > 0) begin
        for (int b = 0; b < HBLANK; b++) begin
          step();
          chk1("fblank_tvalid", m_axis_tvalid, 1'b0);
        end
      end
      for (int c = 0; c < NCOL; c++) begin
        chk1("flush_tready", s_axis_tready, 1'b0);
        step();
        chk1("flush_tvalid", m_axis_tvalid, 1'b1);
        chk8("flush_tdata", m_axis_tdata, 8'h00);
        chk1("flush_tuser", m_axis_tuser, 1'b0);
        chk1("flush_tlast", m_axis_tlast, (c == NCOL - 1));
        chk1("flush_no_done", frame_done, 1'b0);
      end
    end
    enable = keep_en;
    step();
    chk1("frame_done", frame_done, 1'b1);
    chk1("done_tvalid", m_axis_tvalid, 1'b0);
    chk1("done_errur", err_underrun, ur);
    chk1("done_errll", err_line_len, ll);
    chk1("done_busy", busy, keep_en);
    if (!keep_en) begin
      step();
      chk1("done_pulse", frame_done, 1'b0);
    end
  endtask

  initial begin
    step();
    step();
    chk_quiet("reset");
    rst = 1'b0;
    step();
    chk_quiet("idle");

    do_frame(0, 0, 0, NCOL - 1, -1, -1, 1'b0);
    do_frame(2, 0, 0, NCOL - 1, -1, -1, 1'b0);
    do_frame(0, 4, 3, NCOL - 1, -1, -1, 1'b0);
    do_frame(0, 0, 0, 5, -1, -1, 1'b0);
    do_frame(0, 0, 0, 5, 2, 3, 1'b0);

`ifdef DEMOSAIC_CTRL_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) do_frame(0, 0, 0, NCOL - 1, -1, -1, 1'b1);
    step();
    chk16("frame_cnt", frame_cnt, 16'd3);
    chk16("underrun_cnt", underrun_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
